data_memory_responder: RTL

Single-port synchronous data memory that answers the load/store requests the processor pipeline issues from its execute stage (`read`, `write`, `address`, write data). Load data is returned one cycle later, which is when the write-back stage consumes it. After every reset a clear sequencer zeroes the whole array before any request is served. Protocol violations are recorded in sticky error flags.

---
 rtl/data_memory_responder_if.sv | 31 +++
 rtl/data_memory_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// Load/store bus between the pipeline (master) and the data memory (slave).
//   read, write   : request strobes, sampled on the rising clock edge
//   address       : word address of the request
//   wdata         : store data
//   rdata         : load data, valid while rdata_valid is high
//   rdata_valid   : one-cycle pulse marking fresh rdata
//   busy          : memory is running its post-reset clear sequence
//   err           : sticky protocol error flags {range, busy, read+write}
interface data_memory_responder_if #(
   parameter int unsigned D_BITS = 32,
   parameter int unsigned A_BITS = 10
);
   logic              read;
   logic              write;
   logic [A_BITS-1:0] address;
   logic [D_BITS-1:0] wdata;
   logic [D_BITS-1:0] rdata;
   logic              rdata_valid;
   logic              busy;
   logic [2:0]        err;

   modport master (
      output read, write, address, wdata,
      input  rdata, rdata_valid, busy, err
   );

   modport slave (
      input  read, write, address, wdata,
      output rdata, rdata_valid, busy, err
   );
endinterface

// File: rtl/data_memory_responder.sv
// Single-port synchronous data memory answering execute-stage loads/stores.
// A clear sequencer zeroes every word after reset before requests are served;
// loads return one cycle after they are sampled; protocol errors are sticky.
//   clk   : rising-edge clock
//   nrst  : asynchronous active-low reset
//   bus   : slave side of the load/store bus (see data_memory_responder_if)
module data_memory_responder #(
   parameter int unsigned D_BITS = 32,
   parameter int unsigned A_BITS = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input logic                    clk,
   input logic                    nrst,
   data_memory_responder_if.slave bus
);

   localparam int unsigned IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [D_BITS-1:0]   r_mem [DEPTH];
   logic [IDX_BITS-1:0] r_cnt;
   logic [D_BITS-1:0]   r_rdata;
   logic                r_rdata_valid;
   logic                r_busy;
   logic [2:0]          r_err;

   logic                w_in_range;
   logic                w_req;
   logic [IDX_BITS-1:0] w_req_idx;
   logic                w_mem_we;
   logic [IDX_BITS-1:0] w_mem_idx;
   logic [D_BITS-1:0]   w_mem_wdata;
   logic                w_rd_en;
   logic                w_cnt_inc;
   logic [2:0]          w_err_set;

   // Range check is done on the full address before it is truncated to an index.
   assign w_in_range = ({1'b0, bus.address} < (A_BITS + 1)'(DEPTH));
   assign w_req      = bus.read | bus.write;
   assign w_req_idx  = bus.address[IDX_BITS-1:0];

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: leave CLEAR on the edge that zeroes the last word
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_CLEAR: if (r_cnt == LAST_IDX) w_next_state = ST_READY;
         ST_READY: w_next_state = ST_READY;
         default:  w_next_state = ST_CLEAR;
      endcase
   end

   // Output/control decode per state
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_idx   = '0;
      w_mem_wdata = '0;
      w_rd_en     = 1'b0;
      w_cnt_inc   = 1'b0;
      w_err_set   = '0;
      case (r_state)
         ST_CLEAR: begin
            // Requests during the clear are dropped and flagged.
            w_mem_we     = 1'b1;
            w_mem_idx    = r_cnt;
            w_cnt_inc    = 1'b1;
            w_err_set[1] = w_req;
         end
         ST_READY: begin
            w_mem_we     = bus.write & w_in_range;
            w_mem_idx    = w_req_idx;
            w_mem_wdata  = bus.wdata;
            w_rd_en      = bus.read;
            w_err_set[0] = bus.read & bus.write;
            w_err_set[2] = w_req & ~w_in_range;
         end
         default: ;
      endcase
   end

   // Array write port (clear or store); no reset on the storage itself
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_idx] <= w_mem_wdata;
      end
   end

   // Clear counter, load data, status and sticky error registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_busy        <= 1'b1;
         r_err         <= '0;
      end else begin
         if (w_cnt_inc) begin
            r_cnt <= r_cnt + IDX_BITS'(1);
         end
         // Non-blocking read of the array gives read-before-write on read+write.
         if (w_rd_en) begin
            r_rdata <= w_in_range ? r_mem[w_req_idx] : '0;
         end
         r_rdata_valid <= w_rd_en;
         r_busy        <= (w_next_state == ST_CLEAR);
         r_err         <= r_err | w_err_set;
      end
   end

   assign bus.rdata       = r_rdata;
   assign bus.rdata_valid = r_rdata_valid;
   assign bus.busy        = r_busy;
   assign bus.err         = r_err;

endmodule
